sevenseg_scan_driver: RTL and testbench

- Parametrised successor to the single-digit seven-segment decoder.
- Drives NUM_DIGITS time-multiplexed common-anode/cathode digits from one shared segment bus.
- Hex decode covers 0-F. Each digit has its own decimal point and blank bit.
- Display data is double-buffered, so the display never shows a torn frame.
- Sits between the system register/counter logic and the board's display pins.

---
 rtl/sevenseg_pkg.sv | 28 ++
 rtl/sevenseg_hex_decode.sv | 13 +
 rtl/sevenseg_scan_driver.sv | 156 +++++++++++++++
 tb/tb_sevenseg_scan_driver.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared seven-segment definitions: segment bit positions, the 0-F glyph
// table (active-high, bit0=a .. bit6=g) and the output polarity helper.
package sevenseg_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    localparam logic SEG_ON  = 1'b1;
    localparam logic SEG_OFF = 1'b0;

    // Map a logical on/off request to the pin level for the given polarity.
    function automatic logic drive_level(input logic on, input bit active_low);
        return (on ? SEG_ON : SEG_OFF) ^ active_low;
    endfunction

endpackage

// File: rtl/sevenseg_hex_decode.sv
// Combinational nibble to active-high seven-segment glyph (bit0=a .. bit6=g).
module sevenseg_hex_decode
    import sevenseg_pkg::*;
(
    input  logic [3:0]           nibble,
    output logic [SEG_G:SEG_A]   pattern
);

    always_comb begin
        pattern = HEX_SEG[nibble];
    end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed NUM_DIGITS hex display driver with double-buffered data.
// Optional leading-zero suppression: SEVENSEG_SCAN_LEADING_ZERO_BLANK_EN.
module sevenseg_scan_driver
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 50000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     blank_in,
    output logic [6:0]                segments,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     anode,
    output logic                      frame_tick
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam bit SEG_LOW = (SEG_ACTIVE_LOW != 0);
    localparam bit AN_LOW  = (AN_ACTIVE_LOW != 0);
    localparam logic [6:0]            SEG_IDLE = {7{SEG_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_IDLE  = {NUM_DIGITS{AN_LOW}};

    logic [CNT_W-1:0]          prescaler_q, prescaler_d;
    logic                      started_q, started_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0]   pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0]     pend_dp_q, pend_dp_d;
    logic [NUM_DIGITS-1:0]     pend_blank_q, pend_blank_d;
    logic [4*NUM_DIGITS-1:0]   shd_val_q, shd_val_d;
    logic [NUM_DIGITS-1:0]     shd_dp_q, shd_dp_d;
    logic [NUM_DIGITS-1:0]     shd_blank_q, shd_blank_d;
    logic [6:0]                seg_q, seg_d;
    logic                      dp_q, dp_d;
    logic [NUM_DIGITS-1:0]     anode_q, anode_d;
    logic                      frame_tick_q, frame_tick_d;

    logic                      adv;
    logic                      wrap;
    logic                      frame_start;
    logic [3:0]                cur_nibble;
    logic [6:0]                cur_pattern;
    logic                      cur_blank;
    logic [NUM_DIGITS-1:0]     auto_blank;

    // The first prescaler rollover after reset starts the scan on digit 0
    // instead of stepping, so digit 0 is the first digit lit.
    always_comb begin
        adv          = (prescaler_q == CNT_LAST);
        prescaler_d  = adv ? '0 : prescaler_q + 1'b1;
        started_d    = started_q | adv;
        wrap         = adv & started_q & (idx_q == IDX_LAST);
        frame_start  = wrap | (adv & ~started_q);
        frame_tick_d = wrap;

        idx_d = idx_q;
        if (adv && started_q) begin
            idx_d = wrap ? '0 : idx_q + 1'b1;
        end

        pend_val_d   = load ? value    : pend_val_q;
        pend_dp_d    = load ? dp_in    : pend_dp_q;
        pend_blank_d = load ? blank_in : pend_blank_q;

        // pending_d already carries a same-cycle load, giving the bypass.
        shd_val_d   = frame_start ? pend_val_d   : shd_val_q;
        shd_dp_d    = frame_start ? pend_dp_d    : shd_dp_q;
        shd_blank_d = frame_start ? pend_blank_d : shd_blank_q;
    end

`ifdef SEVENSEG_SCAN_LEADING_ZERO_BLANK_EN
    logic zero_run;

    always_comb begin
        auto_blank = '0;
        zero_run   = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run      = zero_run & (shd_val_q[4*k +: 4] == 4'h0) & ~shd_dp_q[k];
            auto_blank[k] = zero_run;
        end
    end
`else
    always_comb begin
        auto_blank = '0;
    end
`endif

    sevenseg_hex_decode u_hex_decode (
        .nibble  (cur_nibble),
        .pattern (cur_pattern)
    );

    always_comb begin
        cur_nibble = shd_val_q[4*idx_q +: 4];
        cur_blank  = shd_blank_q[idx_q] | auto_blank[idx_q];

        seg_d   = SEG_IDLE;
        dp_d    = SEG_LOW;
        anode_d = AN_IDLE;
        if (started_q) begin
            for (int b = 0; b < 7; b++) begin
                seg_d[b] = drive_level(cur_pattern[b] & ~cur_blank, SEG_LOW);
            end
            dp_d = drive_level(shd_dp_q[idx_q] & ~cur_blank, SEG_LOW);
            for (int k = 0; k < NUM_DIGITS; k++) begin
                anode_d[k] = drive_level(IDX_W'(k) == idx_q, AN_LOW);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler_q  <= '0;
            started_q    <= 1'b0;
            idx_q        <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '1;
            shd_val_q    <= '0;
            shd_dp_q     <= '0;
            shd_blank_q  <= '1;
            seg_q        <= SEG_IDLE;
            dp_q         <= SEG_LOW;
            anode_q      <= AN_IDLE;
            frame_tick_q <= 1'b0;
        end else begin
            prescaler_q  <= prescaler_d;
            started_q    <= started_d;
            idx_q        <= idx_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_blank_q <= pend_blank_d;
            shd_val_q    <= shd_val_d;
            shd_dp_q     <= shd_dp_d;
            shd_blank_q  <= shd_blank_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            anode_q      <= anode_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign segments   = seg_q;
    assign dp         = dp_q;
    assign anode      = anode_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Bench for sevenseg_scan_driver (4 digits, 4-cycle dwell, active-low pins):
// directed frames followed by random loads, checked against a timing model.
module tb_sevenseg_scan_driver;

  localparam int N     = 4;
  localparam int DIV   = 4;
  localparam int FRAME = N * DIV;

  localparam logic [6:0] HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic [6:0]  segments;
  logic        dp;
  logic [3:0]  anode;
  logic        frame_tick;

  sevenseg_scan_driver #(
    .NUM_DIGITS(N), .CLK_DIV(DIV), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
    .blank_in(blank_in), .segments(segments), .dp(dp), .anode(anode),
    .frame_tick(frame_tick)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    int          edge_n;
    logic [15:0] val;
    logic [3:0]  dpv;
    logic [3:0]  blk;
  } load_t;

  load_t load_log[$];   // every load the DUT accepted, with its edge number
  load_t sched[$];      // directed loads, keyed by the edge they should hit
  int t;                // clock edges since reset release
  int n_checks;
  int n_errors;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
    end
  endtask

  // Reference: digit k is lit during dwell slots counted from the first
  // prescaler rollover; each frame shows the newest load at or before its
  // starting edge.
  function automatic void model(input int tt, output logic [6:0] e_seg, output logic e_dp,
                                output logic [3:0] e_an, output logic e_ft);
    int d;
    int f;
    int se;
    logic [15:0] v;
    logic [3:0] dpv;
    logic [3:0] blk;
    logic dark;
    e_seg = 7'h7F;
    e_dp  = 1'b1;
    e_an  = 4'hF;
    e_ft  = (tt >= DIV + FRAME) && ((tt - DIV) % FRAME == 0);
    if (tt < DIV + 1) return;
    d  = ((tt - DIV - 1) / DIV) % N;
    f  = (tt - DIV - 1) / FRAME;
    se = DIV + f * FRAME;
    v = '0;
    dpv = '0;
    blk = '1;
    foreach (load_log[i]) begin
      if (load_log[i].edge_n <= se) begin
        v   = load_log[i].val;
        dpv = load_log[i].dpv;
        blk = load_log[i].blk;
      end
    end
    dark = blk[d];
`ifdef SEVENSEG_SCAN_LEADING_ZERO_BLANK_EN
    if (d > 0 && (v >> (4 * d)) == 16'h0 && (dpv >> d) == 4'h0) dark = 1'b1;
`endif
    e_an = ~(4'b0001 << d);
    if (!dark) begin
      e_seg = ~HEX[v[4*d +: 4]];
      e_dp  = ~dpv[d];
    end
  endfunction

  task automatic add_sched(input int e, input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    load_t s;
    s.edge_n = e;
    s.val = v;
    s.dpv = d;
    s.blk = b;
    sched.push_back(s);
  endtask

  // driver: set inputs for edge t+1, clock, log the load, check at negedge
  task automatic run_cycle(input bit rand_en);
    logic [6:0] es;
    logic ed;
    logic [3:0] ea;
    logic ef;
    load_t rec;
    int nxt;
    logic [15:0] mask;
    nxt = t + 1;
    load = 1'b0;
    foreach (sched[i]) begin
      if (sched[i].edge_n == nxt) begin
        load = 1'b1;
        value = sched[i].val;
        dp_in = sched[i].dpv;
        blank_in = sched[i].blk;
      end
    end
    if (rand_en && ($urandom_range(0, 7) == 0 ||
        (((nxt - DIV) % FRAME == 0) && $urandom_range(0, 1) == 1))) begin
      case ($urandom_range(0, 3))
        0: mask = 16'h000F;
        1: mask = 16'h00FF;
        2: mask = 16'h0FFF;
        default: mask = 16'hFFFF;
      endcase
      load = 1'b1;
      value = 16'($urandom) & mask;
      dp_in = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      blank_in = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
    end
    @(posedge clk);
    t++;
    if (load) begin
      rec.edge_n = t;
      rec.val = value;
      rec.dpv = dp_in;
      rec.blk = blank_in;
      load_log.push_back(rec);
    end
    @(negedge clk);
    model(t, es, ed, ea, ef);
    check_eq("segments", 32'(segments), 32'(es));
    check_eq("dp", 32'(dp), 32'(ed));
    check_eq("anode", 32'(anode), 32'(ea));
    check_eq("frame_tick", 32'(frame_tick), 32'(ef));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    t = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset_segments", 32'(segments), 32'h7F);
    check_eq("reset_dp", 32'(dp), 32'h1);
    check_eq("reset_anode", 32'(anode), 32'hF);
    check_eq("reset_frame_tick", 32'(frame_tick), 32'h0);

    add_sched(2,   16'hFEDC, 4'b0000, 4'b0000);
    add_sched(10,  16'hBA98, 4'b0000, 4'b0000);
    add_sched(25,  16'h1234, 4'b0000, 4'b0000);
    add_sched(27,  16'h5678, 4'b0000, 4'b0000);
    add_sched(52,  16'hAAAA, 4'b0000, 4'b0000);
    add_sched(60,  16'h1357, 4'b0001, 4'b0100);
    add_sched(84,  16'h0040, 4'b0000, 4'b0000);
    add_sched(100, 16'h0000, 4'b0000, 4'b0000);

    rst_n = 1'b1;
    t = 0;
    repeat (120) run_cycle(1'b0);
    repeat (200) run_cycle(1'b1);

    // park the scan partway through digit 2, then pulse reset
    for (int i = 0; i < 64 && !(((t - DIV - 1) / DIV) % N == 2 && (t - DIV - 1) % DIV == 1); i++)
      run_cycle(1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midscan_reset_segments", 32'(segments), 32'h7F);
    check_eq("midscan_reset_dp", 32'(dp), 32'h1);
    check_eq("midscan_reset_anode", 32'(anode), 32'hF);
    check_eq("midscan_reset_frame_tick", 32'(frame_tick), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    t = 0;
    load_log.delete();
    sched.delete();
    repeat (150) run_cycle(1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
